// File: rtl/mem_tile_perf_monitor.sv
// Tile-level memory performance monitor: counts tiles, active cycles,
// and accepted requests. It only observes the request handshake.
module mem_tile_perf_monitor #(
  parameter int PC_DATA_WIDTH = 64,
  parameter int SIZE_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pc_clear,
  input  logic                     pc_freeze,
  input  logic                     tile_start,
  input  logic                     tile_done,
  input  logic                     req_valid,
  input  logic                     req_ready,
  input  logic [SIZE_WIDTH-1:0]    req_size,
  output logic [PC_DATA_WIDTH-1:0] pc_num_tiles,
  output logic [PC_DATA_WIDTH-1:0] pc_tot_cycles,
  output logic [PC_DATA_WIDTH-1:0] pc_tot_requests,
  output logic [PC_DATA_WIDTH-1:0] pc_size_per_requests,
  output logic                     busy,
  output logic                     protocol_err
);

  localparam int EXT_W =
    (PC_DATA_WIDTH > SIZE_WIDTH) ? PC_DATA_WIDTH : SIZE_WIDTH;

  typedef logic [PC_DATA_WIDTH-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic active;
  logic accept;
  logic tile_inc;
  logic req_inc;
  logic err_set;

  logic [EXT_W-1:0] size_ext;

  cnt_t num_tiles_q, num_tiles_d;
  cnt_t tot_cycles_q, tot_cycles_d;
  cnt_t tot_reqs_q, tot_reqs_d;
  cnt_t size_q, size_d;

  logic err_q, err_d;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(
    input cnt_t v,
    input logic en
  );
    if (en && (v != CNT_MAX)) begin
      return v + cnt_t'(1);
    end
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tile_start) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (tile_done && !tile_start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active   = (state_q == ACTIVE);
    accept   = req_valid & req_ready;
    tile_inc = active & tile_done;
    req_inc  = active & accept;
    err_set  = (!active & (accept | tile_done))
             | (active & tile_start & !tile_done);
    size_ext = EXT_W'(req_size);
  end

  // Clear beats freeze, freeze beats any increment.
  always_comb begin
    num_tiles_d  = num_tiles_q;
    tot_cycles_d = tot_cycles_q;
    tot_reqs_d   = tot_reqs_q;
    size_d       = size_q;
    err_d        = err_q | err_set;
    if (pc_clear) begin
      num_tiles_d  = '0;
      tot_cycles_d = '0;
      tot_reqs_d   = '0;
      size_d       = '0;
      err_d        = 1'b0;
    end else if (!pc_freeze) begin
      num_tiles_d  = sat_inc(num_tiles_q, tile_inc);
      tot_cycles_d = sat_inc(tot_cycles_q, active);
      tot_reqs_d   = sat_inc(tot_reqs_q, req_inc);
      if (req_inc) begin
        size_d = size_ext[PC_DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      num_tiles_q  <= '0;
      tot_cycles_q <= '0;
      tot_reqs_q   <= '0;
      size_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_tiles_q  <= num_tiles_d;
      tot_cycles_q <= tot_cycles_d;
      tot_reqs_q   <= tot_reqs_d;
      size_q       <= size_d;
      err_q        <= err_d;
    end
  end

  assign pc_num_tiles         = num_tiles_q;
  assign pc_tot_cycles        = tot_cycles_q;
  assign pc_tot_requests      = tot_reqs_q;
  assign pc_size_per_requests = size_q;
  assign busy                 = (state_q == ACTIVE);
  assign protocol_err         = err_q;

endmodule

// File: doc/mem_tile_perf_monitor.md
MEM_TILE_PERF_MONITOR -- requirements
Module: mem_tile_perf_monitor

Interface
REQ-001 SHALL have parameter PC_DATA_WIDTH, default 64, meaning the width of every counter output.
REQ-002 SHALL have parameter SIZE_WIDTH, default 16, meaning the width of the request-size input in bytes.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pc_clear, input, 1 bit: zero all counters; pulsed by the controller at program start.
REQ-006 SHALL have port pc_freeze, input, 1 bit: hold all counters while the performance-counter dump is in progress.
REQ-007 SHALL have port tile_start, input, 1 bit: single-cycle pulse marking the start of a buffer tile transfer.
REQ-008 SHALL have port tile_done, input, 1 bit: single-cycle pulse marking the end of a tile transfer.
REQ-009 SHALL have port req_valid, input, 1 bit: memory-request valid from the buffer's AXI address channel.
REQ-010 SHALL have port req_ready, input, 1 bit: memory-request ready.
REQ-011 SHALL have port req_size, input, SIZE_WIDTH bits: bytes in the current request.
REQ-012 SHALL have port pc_num_tiles, output, PC_DATA_WIDTH bits: number of completed tiles.
REQ-013 SHALL have port pc_tot_cycles, output, PC_DATA_WIDTH bits: number of cycles spent in ACTIVE.
REQ-014 SHALL have port pc_tot_requests, output, PC_DATA_WIDTH bits: number of accepted requests.
REQ-015 SHALL have port pc_size_per_requests, output, PC_DATA_WIDTH bits: req_size of the last accepted request, zero-extended.
REQ-016 SHALL have port busy, output, 1 bit: high while the state is ACTIVE.
REQ-017 SHALL have port protocol_err, output, 1 bit: sticky flag for a pulse-ordering violation.

Function
REQ-018 SHALL implement a two-state FSM with states IDLE and ACTIVE, registered as state_q.
- IDLE + tile_start -> ACTIVE.
- ACTIVE + tile_done -> IDLE.
- ACTIVE + tile_done + tile_start in the same cycle -> stay ACTIVE (back-to-back tiles).
REQ-019 SHALL increment pc_num_tiles by 1 on each tile_done accepted in ACTIVE, including the back-to-back case.
REQ-020 SHALL increment pc_tot_cycles by 1 in every cycle where state_q == ACTIVE.
- Start pulse at cycle t and done pulse at cycle t+k therefore add exactly k.
REQ-021 SHALL treat a request as accepted when req_valid && req_ready; handshake acceptance is independent of state.
REQ-022 SHALL, on an accepted request while state_q == ACTIVE, increment pc_tot_requests by 1 and load pc_size_per_requests with req_size.
REQ-023 SHALL, on an accepted request while state_q == IDLE, leave the counters unchanged and set protocol_err.
REQ-024 SHALL treat tile_start while ACTIVE without tile_done as follows: ignore it, stay ACTIVE, and set protocol_err.
REQ-025 SHALL treat tile_done while IDLE as follows: ignore it, leave pc_num_tiles unchanged, and set protocol_err.
REQ-026 SHALL register all outputs; the effect of an event at cycle t is visible at cycle t+1.
REQ-027 SHALL saturate every counter at all-ones; no wrap to zero.
REQ-028 SHALL, while pc_freeze is high, hold all counters. FSM transitions continue; events during the freeze are lost, not deferred.
REQ-029 SHALL, on pc_clear, zero all counters and protocol_err on the next edge and leave the FSM state unchanged.
REQ-030 SHALL give pc_clear priority over pc_freeze and over any increment in the same cycle.
REQ-031 SHALL never stall or backpressure req_valid/req_ready; the block is observe-only.

Reset
REQ-032 SHALL, on reset, set state_q to IDLE and force all counters, busy and protocol_err to 0 on the next edge.
REQ-033 SHALL give reset priority over pc_clear, pc_freeze and all events.
REQ-034 SHALL, on reset mid-tile, abandon the partial tile; the cycles already counted are discarded along with everything else.

Verification
REQ-035 SHALL cover basic accounting:
- Stimulus: tile_start at cycle 10, three accepted requests of sizes 64, 64, 32 at cycles 12, 15, 20, tile_done at cycle 25.
- Response: num_tiles=1, tot_cycles=15, tot_requests=3, size_per_requests=32, protocol_err=0.
REQ-036 SHALL cover back-to-back tiles:
- Stimulus: tile_start at cycle 0; tile_done+tile_start together at cycle 8; tile_done at cycle 12.
- Response: num_tiles=2, tot_cycles=12, busy low from cycle 13.
REQ-037 SHALL cover protocol errors:
- Stimulus: tile_done in IDLE.
- Response: protocol_err=1 and num_tiles=0.
- Stimulus: an accepted request in IDLE.
- Response: tot_requests stays 0.
REQ-038 SHALL cover freeze and clear:
- Stimulus: pc_freeze high for 5 cycles mid-tile.
- Response: tot_cycles is 5 less than unfrozen; busy stays 1.
- Stimulus: pc_clear and pc_freeze together.
- Response: all counters 0 next cycle.
REQ-039 SHALL cover saturation:
- Stimulus: PC_DATA_WIDTH=8, ACTIVE for 300 cycles.
- Response: tot_cycles=255, holds at 255.
REQ-040 SHALL cover reset mid-tile:
- Stimulus: reset asserted at cycle 5 of an ACTIVE tile with 2 requests counted.
- Response: all outputs 0 next cycle, state IDLE, and the following tile counts from zero.
